muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/booth_recode.sv | 22 ++
 rtl/muldiv_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Holds the FSM state type, opcodes, iteration counts, the Booth select type
// and a small conditional-negate helper used by the signed-divide option
// (MULDIV_SIGNED_DIV_EN).
package muldiv_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MUL_ITERS = WIDTH / 2;
    localparam int unsigned DIV_ITERS = WIDTH;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned OP_W      = 5;

    localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        DIV_FIX,
        DONE
    } state_t;

    // Radix-4 Booth digit as select lines: zero, else magnitude 1 or 2, then sign.
    typedef struct packed {
        logic neg;
        logic zero;
        logic two;
    } booth_sel_t;

    function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier group
// {b[2i+1], b[2i], b[2i-1]} -> digit in {-2,-1,0,+1,+2} as select lines.
// Ports:
//   bits    in  3  multiplier group, bits[0] is the lower overlap bit
//   neg_c   out 1  digit is negative
//   zero_c  out 1  digit is zero
//   two_c   out 1  digit magnitude is 2 (else 1 when not zero)
module booth_recode (
    input  logic [2:0] bits,
    output logic       neg_c,
    output logic       zero_c,
    output logic       two_c
);

    // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
    always_comb begin
        neg_c  = bits[2] & ~(bits[1] & bits[0]);
        zero_c = (bits == 3'b000) | (bits == 3'b111);
        two_c  = (bits[2] ^ bits[1]) & ~(bits[1] ^ bits[0]);
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle 32x32 signed multiply (radix-4 Booth, 16 iterations) and 32/32
// non-restoring divide (32 iterations + one fix-up cycle) driving HI/LO.
// Optional: MULDIV_SIGNED_DIV_EN makes DIV signed (magnitude divide, sign
// correction in DIV_FIX); otherwise DIV is unsigned.
// Ports:
//   clock        in   1  system clock, rising edge
//   clear        in   1  asynchronous active-high reset
//   start        in   1  request, sampled in IDLE/DONE only
//   opcode       in   5  OP_MUL / OP_DIV, anything else ignored
//   A            in  32  multiplicand / dividend
//   B            in  32  multiplier / divisor
//   busy         out  1  high in MUL, DIV, DIV_FIX
//   done         out  1  one-cycle result-valid pulse
//   div_by_zero  out  1  DIV with B==0, held until next accepted start
//   Chigh        out 32  product high / remainder
//   Clow         out 32  product low / quotient
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Chigh,
    output logic [WIDTH-1:0] Clow
);

    localparam int unsigned AW = 2 * WIDTH;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;

    logic [AW-1:0]    acc;      // product accumulator, wraps mod 2^64
    logic [AW-1:0]    mcand;    // sign-extended A, pre-shifted by 2i
    logic [WIDTH:0]   mplier;   // {B, 0}; low 3 bits are the current Booth group

    logic [WIDTH:0]   rem;      // signed partial remainder
    logic [WIDTH-1:0] quo;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvsr;

`ifdef MULDIV_SIGNED_DIV_EN
    logic             q_neg;
    logic             r_neg;
`endif

    logic             op_valid, accept, div_zero;
    logic             neg_c, zero_c, two_c;
    booth_sel_t       sel;
    logic [AW-1:0]    pp_mag, pp, acc_sum;
    logic [WIDTH:0]   rem_sh, rem_step;
    logic [WIDTH-1:0] quo_step, rem_fix;

    assign op_valid = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign accept   = start && op_valid && ((state == IDLE) || (state == DONE));
    assign div_zero = (opcode == OP_DIV) && (B == '0);

    booth_recode u_booth (
        .bits   (mplier[2:0]),
        .neg_c  (neg_c),
        .zero_c (zero_c),
        .two_c  (two_c)
    );

    assign sel = {neg_c, zero_c, two_c};

    // Booth partial product and accumulator update
    always_comb begin
        pp_mag = '0;
        if (!sel.zero) begin
            pp_mag = sel.two ? (mcand << 1) : mcand;
        end
        pp      = sel.neg ? -pp_mag : pp_mag;
        acc_sum = acc + pp;
    end

    // Non-restoring step: operation chosen by the sign of R before the shift,
    // so the 33-bit wrap of the shifted value never affects the result.
    always_comb begin
        rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_step = rem[WIDTH] ? (rem_sh + {1'b0, dvsr}) : (rem_sh - {1'b0, dvsr});
        quo_step = {quo[WIDTH-2:0], ~rem_step[WIDTH]};
        rem_fix  = rem[WIDTH] ? (rem[WIDTH-1:0] + dvsr) : rem[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_next = MUL;
                    end else begin
                        state_next = div_zero ? DONE : DIV;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                if (count == CNT_W'(MUL_ITERS - 1)) begin
                    state_next = DONE;
                end
            end
            DIV: begin
                if (count == CNT_W'(DIV_ITERS - 1)) begin
                    state_next = DIV_FIX;
                end
            end
            DIV_FIX: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count       <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Chigh       <= '0;
            Clow        <= '0;
`ifdef MULDIV_SIGNED_DIV_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            busy <= state_next inside {MUL, DIV, DIV_FIX};
            done <= (state_next == DONE);

            if (accept) begin
                count       <= '0;
                acc         <= '0;
                mcand       <= {{WIDTH{A[WIDTH-1]}}, A};
                mplier      <= {B, 1'b0};
                rem         <= '0;
                div_by_zero <= div_zero;
`ifdef MULDIV_SIGNED_DIV_EN
                quo         <= negate_if(A[WIDTH-1], A);
                dvsr        <= negate_if(B[WIDTH-1], B);
                q_neg       <= A[WIDTH-1] ^ B[WIDTH-1];
                r_neg       <= A[WIDTH-1];
`else
                quo         <= A;
                dvsr        <= B;
`endif
                if (div_zero) begin
                    Chigh <= A;
                    Clow  <= '1;
                end
            end else begin
                case (state)
                    MUL: begin
                        count  <= count + CNT_W'(1);
                        acc    <= acc_sum;
                        mcand  <= mcand << 2;
                        mplier <= {2'b00, mplier[WIDTH:2]};
                        if (state_next == DONE) begin
                            Chigh <= acc_sum[AW-1:WIDTH];
                            Clow  <= acc_sum[WIDTH-1:0];
                        end
                    end
                    DIV: begin
                        count <= count + CNT_W'(1);
                        rem   <= rem_step;
                        quo   <= quo_step;
                    end
                    DIV_FIX: begin
`ifdef MULDIV_SIGNED_DIV_EN
                        Chigh <= negate_if(r_neg, rem_fix);
                        Clow  <= negate_if(q_neg, quo);
`else
                        Chigh <= rem_fix;
                        Clow  <= quo;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer. Edge E0 is the edge that
// samples start; done is expected after E16 (MUL), E33 (DIV: 32 iterations
// plus DIV_FIX) and E0 itself (DIV by zero).
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] chigh;
    logic [31:0] clow;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Chigh       (chigh),
        .Clow        (clow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance until done, counting edges after E0 and cycles with busy high.
    task automatic wait_done(input int edges_in, input int busy_in, output int edges, output int busy_cycles);
        edges       = edges_in;
        busy_cycles = busy_in;
        while (!done && edges < 60) begin
            if (busy) busy_cycles++;
            step();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_edges,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
        int edges;
        int busy_cycles;
        opcode = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        step();
        start  = 1'b0;
        opcode = 5'b00000;
        a      = 32'hDEADBEEF;
        b      = 32'h0BADF00D;
        wait_done(0, 0, edges, busy_cycles);
        check({tag, "_done"},  64'(done), 64'(1'b1));
        check({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_edges));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(1'b0));
        check({tag, "_chigh"}, 64'(chigh), 64'(exp_hi));
        check({tag, "_clow"},  64'(clow),  64'(exp_lo));
        check({tag, "_dbz"},   64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        int edges;
        int busy_cycles;

        clear  = 1'b1;
        start  = 1'b0;
        opcode = 5'b00000;
        a      = 32'h0;
        b      = 32'h0;
        repeat (3) step();
        check("rst_busy",  64'(busy), 64'(1'b0));
        check("rst_done",  64'(done), 64'(1'b0));
        check("rst_dbz",   64'(div_by_zero), 64'(1'b0));
        check("rst_chigh", 64'(chigh), 64'h0);
        check("rst_clow",  64'(clow), 64'h0);
        clear = 1'b0;
        step();

        // 7 * -3 = -21
        run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD, 16, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        step();
        check("done_pulse_one_cycle", 64'(done), 64'(1'b0));

        // (-2^31)^2 = 2^62
        run_op("mul_min_min", OP_MUL, 32'h80000000, 32'h80000000, 16, 32'h40000000, 32'h00000000, 1'b0);
        step();

        // 100 / 7 = 14 r 2
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 33, 32'h00000002, 32'h0000000E, 1'b0);

`ifdef MULDIV_SIGNED_DIV_EN
        run_op("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
        run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 1'b0);
`else
        run_op("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7, 33, 32'h00000002, 32'h24924916, 1'b0);
        run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h00000000, 1'b0);
`endif
        step();

        // divide by zero, then back-to-back MUL accepted from DONE clears the flag
        run_op("div_zero", OP_DIV, 32'h00001234, 32'h0, 0, 32'h00001234, 32'hFFFFFFFF, 1'b1);
        run_op("mul_b2b_3_5", OP_MUL, 32'd3, 32'd5, 16, 32'h00000000, 32'h0000000F, 1'b0);
        step();

        // invalid opcode is ignored
        opcode = 5'b00001;
        a      = 32'd9;
        b      = 32'd9;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("bad_op_busy", 64'(busy), 64'(1'b0));
        check("bad_op_done", 64'(done), 64'(1'b0));
        check("bad_op_clow", 64'(clow), 64'h0000000F);

        // MUL -5 * 6 with a DIV start pulsed mid-operation
        opcode = OP_MUL;
        a      = 32'hFFFFFFFB;
        b      = 32'd6;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (4) step();
        opcode = OP_DIV;
        a      = 32'd1;
        b      = 32'd0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("hz_busy_after_ignored", 64'(busy), 64'(1'b1));
        check("hz_dbz_after_ignored",  64'(div_by_zero), 64'(1'b0));
        wait_done(5, 5, edges, busy_cycles);
        check("hz_mul_done",  64'(done), 64'(1'b1));
        check("hz_mul_edges", 64'(edges), 64'd16);
        check("hz_mul_chigh", 64'(chigh), 64'hFFFFFFFF);
        check("hz_mul_clow",  64'(clow), 64'hFFFFFFE2);
        check("hz_mul_dbz",   64'(div_by_zero), 64'(1'b0));
        step();

        // clear during DIV iteration 5 abandons the operation immediately
        opcode = OP_DIV;
        a      = 32'd100;
        b      = 32'd7;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (5) step();
        check("clr_busy_before", 64'(busy), 64'(1'b1));
        #2;
        clear = 1'b1;
        #1;
        check("clr_busy",  64'(busy), 64'(1'b0));
        check("clr_done",  64'(done), 64'(1'b0));
        check("clr_chigh", 64'(chigh), 64'h0);
        check("clr_clow",  64'(clow), 64'h0);
        step();
        clear = 1'b0;
        step();

        // 1000 / 10 = 100 r 0 after the clear
        run_op("div_after_clr", OP_DIV, 32'd1000, 32'd10, 33, 32'h00000000, 32'h00000064, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
